// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: operand and opcode widths, the opcode
// encoding, and the helper that identifies single-operand commands.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_OPW   = 3;

  typedef enum logic [ALU_OPW-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_t;

  // Unary commands carry only operand A; their frame has no B byte.
  function automatic logic is_unary(alu_op_t op);
    return (op == OP_NOT) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_frame_loader.sv
// Byte-stream frame assembler in front of the ALU datapath: collects
// opcode / A / (B) bytes and issues one registered command per frame.
module alu_frame_loader
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPW-1:0]   op,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             err,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {
    S_OP,
    S_A,
    S_B,
    S_ISSUE
  } state_t;

  state_t           r_state;
  logic             r_out_valid;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_err;
  logic [7:0]       r_frame_cnt;

  logic             w_accept;
  logic             w_op_legal;

  // Ready is held low during reset so no byte is consumed by a resetting loader.
  assign in_ready   = rst_n && (r_state != S_ISSUE);
  assign w_accept   = in_valid && in_ready;
  assign w_op_legal = (in_data[WIDTH-1:OPW] == '0);

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_OP;
      r_out_valid <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_OP: begin
          if (w_accept) begin
            if (w_op_legal) begin
              r_op    <= in_data[OPW-1:0];
              r_state <= S_A;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_A: begin
          if (w_accept) begin
            r_a <= in_data;
            if (is_unary(alu_op_t'(r_op))) begin
              r_b         <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_ISSUE;
            end else begin
              r_state <= S_B;
            end
          end
        end
        S_B: begin
          if (w_accept) begin
            r_b         <= in_data;
            r_out_valid <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 8'd1;
            r_state     <= S_OP;
          end
        end
        default: r_state <= S_OP;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign op        = r_op;
  assign a         = r_a;
  assign b         = r_b;
  assign err       = r_err;
  assign frame_cnt = r_frame_cnt;

endmodule
